mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_lane_fmt.sv | 21 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: access modes, FSM states and grant sources.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RESP  = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

    // Anything other than the byte encoding is handled as a word access.
    function automatic logic is_byte(input logic [1:0] mode);
        return mode == MEM_BYTE;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: load extraction with sign/zero extension, and store-byte merge.
module mem_lane_fmt (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    input  logic        signed_i,
    input  logic [7:0]  wbyte_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = word_i[8*lane_i +: 8];
        load_o    = byte_i ? {{24{signed_i & lane_byte[7]}}, lane_byte} : word_i;
        merge_o   = word_i;
        merge_o[8*lane_i +: 8] = wbyte_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and data access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [1:0]        d_mode,
    input  logic              d_signed,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e              state_q, state_d;
    src_e                last_q, src_q, gnt;
    logic                wr_q, byte_q, sgn_q;
    logic [RAM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q, merge_q, if_rdata_q, d_rdata_q;
    logic [31:0]         load_w, merge_w;
    logic                d_req, accept;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:RAM_AW+2], d_addr[31:RAM_AW+2]};

    assign d_req = d_read | d_write;

    mem_lane_fmt u_fmt (
        .word_i   (ram_rdata),
        .lane_i   (addr_q[1:0]),
        .byte_i   (byte_q),
        .signed_i (sgn_q),
        .wbyte_i  (wdata_q[7:0]),
        .load_o   (load_w),
        .merge_o  (merge_w)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        gnt      = SRC_IF;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        if_ready = 1'b0;
        d_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    accept = 1'b1;
                    if (if_req & d_req)
                        gnt = (last_q == SRC_IF) ? SRC_D : SRC_IF;
                    else
                        gnt = d_req ? SRC_D : SRC_IF;
                    state_d = (gnt == SRC_D && d_write && !is_byte(d_mode)) ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                ram_en  = 1'b1;
                // Only byte stores reach RD with the write flag; they need a read-modify-write.
                state_d = (src_q == SRC_D && wr_q) ? ST_MERGE : ST_RESP;
            end
            ST_RESP: begin
                if_ready = (src_q == SRC_IF);
                d_ready  = (src_q == SRC_D);
                state_d  = ST_IDLE;
            end
            ST_MERGE: state_d = ST_WR;
            ST_WR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                d_ready = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = byte_q ? merge_q : wdata_q;
    assign stall     = d_req & ~d_ready;

    // Read data is shown live during the ready pulse and held from the register afterwards.
    assign if_rdata = (state_q == ST_RESP && src_q == SRC_IF) ? ram_rdata : if_rdata_q;
    assign d_rdata  = (state_q == ST_RESP && src_q == SRC_D)  ? load_w    : d_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= SRC_IF;
            src_q      <= SRC_IF;
            wr_q       <= 1'b0;
            byte_q     <= 1'b0;
            sgn_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q  <= gnt;
                src_q   <= gnt;
                wr_q    <= (gnt == SRC_D) && d_write;
                byte_q  <= (gnt == SRC_D) && is_byte(d_mode);
                sgn_q   <= d_signed;
                addr_q  <= (gnt == SRC_D) ? d_addr[RAM_AW+1:0] : if_addr[RAM_AW+1:0];
                wdata_q <= d_wdata;
            end
            if (state_q == ST_MERGE)
                merge_q <= merge_w;
            if (state_q == ST_RESP && src_q == SRC_IF)
                if_rdata_q <= ram_rdata;
            if (state_q == ST_RESP && src_q == SRC_D)
                d_rdata_q <= load_w;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, vector table and scoreboard of expected responses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_read = 1'b0, d_write = 1'b0, d_signed = 1'b0;
    logic [1:0]  d_mode = MEM_WORD;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        if_ready, d_ready, stall, ram_en, ram_we;
    logic [9:0]  ram_addr;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    int          wcount = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [1:0]  mode;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic        src;
        logic [31:0] data;
        int          lat;
        logic        chk_data;
    } exp_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    exp_t sb [$];
    logic [31:0] last_if, last_d;

    mem_arbiter #(.RAM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_mode(d_mode), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wcount <= wcount + 1;
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drop_reqs();
        if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic pop_cmp(input string nm, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_src"}, {31'b0, d_ready}, {31'b0, e.src});
        chk({nm, "_lat"}, 32'(lat), 32'(e.lat));
        if (e.chk_data)
            chk({nm, "_data"}, e.src ? d_rdata : if_rdata, e.data);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat, w0;
        logic got, we_s;
        logic [9:0] wa_s;
        string nm;
        v  = vecs[i];
        nm = $sformatf("v%0d", i);
        preload(v.addr[11:2], v.init);
        w0 = wcount;
        @(negedge clk);
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_read = v.rd; d_write = v.wr; d_mode = v.mode; d_signed = v.sgn;
            d_addr = v.addr; d_wdata = v.wdata;
        end
        sb.push_back('{src: !v.fetch, data: v.exp_data, lat: v.exp_lat, chk_data: !v.wr});
        #1;
        lat = 0; got = 1'b0; we_s = 1'b0; wa_s = '0;
        while (lat < 12) begin
            if (if_ready || d_ready) begin
                got = 1'b1;
                break;
            end
            chk({nm, "_stall"}, {31'b0, stall}, {31'b0, !v.fetch});
            if (lat == 0) chk({nm, "_en_c0"}, {31'b0, ram_en}, 32'd0);
            if (lat == 1) chk({nm, "_en_c1"}, {31'b0, ram_en}, 32'd1);
            @(negedge clk);
            lat++;
        end
        if (!got) begin
            chk({nm, "_timeout"}, {31'b0, got}, 32'd1);
        end else begin
            we_s = ram_we; wa_s = ram_addr;
            pop_cmp(nm, lat);
            chk({nm, "_stall_rdy"}, {31'b0, stall}, 32'd0);
        end
        drop_reqs();
        @(negedge clk);
        @(negedge clk);
        if (v.wr) begin
            chk({nm, "_we"}, {31'b0, we_s}, 32'd1);
            chk({nm, "_waddr"}, {22'b0, wa_s}, {22'b0, v.addr[11:2]});
            chk({nm, "_mem"}, mem[v.addr[11:2]], v.exp_mem);
            chk({nm, "_wcnt"}, 32'(wcount - w0), 32'd1);
        end else begin
            chk({nm, "_wcnt"}, 32'(wcount - w0), 32'd0);
            if (v.fetch) last_if = v.exp_data;
            else         last_d  = v.exp_data;
        end
        chk({nm, "_if_hold"}, if_rdata, last_if);
        chk({nm, "_d_hold"}, d_rdata, last_d);
    endtask

    initial begin
        int   c, n, w0;
        //          fetch rd wr mode      sgn addr          wdata         init          exp_data      lat exp_mem
        vecs[0]  = '{1'b1, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'h10,       32'h0,        32'h8C220004, 32'h8C220004, 2, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h21,       32'h0,        32'h1234F678, 32'hFFFFFFF6, 2, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h21,       32'h0,        32'h1234F678, 32'h000000F6, 2, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h24,       32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 2, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, MEM_WORD, 1'b1, 32'h27,       32'h0,        32'h87654321, 32'h87654321, 2, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h23,       32'h0,        32'h7FAABBCC, 32'h0000007F, 2, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h20,       32'h0,        32'h00000080, 32'hFFFFFF80, 2, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h22,       32'h000000AB, 32'h11223344, 32'h0,        3, 32'h11AB3344};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h07,       32'hDEADBEEF, 32'h0,        32'h0,        1, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h1C,       32'h12345655, 32'hFFFFFFFF, 32'h0,        3, 32'hFFFFFF55};
        vecs[10] = '{1'b0, 1'b1, 1'b1, MEM_WORD, 1'b0, 32'h30,       32'h0BADF00D, 32'h11111111, 32'h0,        1, 32'h0BADF00D};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b01,    1'b1, 32'h21,       32'h0,        32'h1234F678, 32'h1234F678, 2, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'b11,    1'b0, 32'h42,       32'hA5A5A5A5, 32'h0,        32'h0,        1, 32'hA5A5A5A5};
        vecs[13] = '{1'b1, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'hFFF00014, 32'h0,        32'h01020304, 32'h01020304, 2, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h0F,       32'h000000C3, 32'h00000000, 32'h0,        3, 32'hC3000000};

        // Reset state, with both test words loaded while reset is held.
        preload(10'd4, 32'h8C220004);
        preload(10'd8, 32'h1234F678);
        @(negedge clk);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("rst_d_ready",  {31'b0, d_ready},  32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata,  32'd0);
        chk("rst_ram_en",   {31'b0, ram_en}, 32'd0);
        chk("rst_ram_we",   {31'b0, ram_we}, 32'd0);

        // Both ports held from reset: data first, then alternating grants.
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        d_read = 1'b1; d_mode = MEM_WORD; d_signed = 1'b0; d_addr = 32'h20;
        sb.push_back('{src: 1'b1, data: 32'h1234F678, lat: 2,  chk_data: 1'b1});
        sb.push_back('{src: 1'b0, data: 32'h8C220004, lat: 5,  chk_data: 1'b1});
        sb.push_back('{src: 1'b1, data: 32'h1234F678, lat: 8,  chk_data: 1'b1});
        sb.push_back('{src: 1'b0, data: 32'h8C220004, lat: 11, chk_data: 1'b1});
        #1;
        chk("rr_en_after_rst", {31'b0, ram_en}, 32'd0);
        chk("rr_we_after_rst", {31'b0, ram_we}, 32'd0);
        c = 0; n = 0;
        while (c < 20 && n < 4) begin
            if (if_ready || d_ready) begin
                pop_cmp($sformatf("rr%0d", n), c);
                n++;
                if (n == 4) drop_reqs();
            end
            @(negedge clk);
            c++;
        end
        chk("rr_grants", 32'(n), 32'd4);
        chk("rr_if_hold", if_rdata, 32'h8C220004);

        // Reset while a byte store sits in MERGE: nothing may be written.
        preload(10'd8, 32'h11223344);
        w0 = wcount;
        @(negedge clk);
        d_write = 1'b1; d_mode = MEM_BYTE; d_addr = 32'h22; d_wdata = 32'h000000AB;
        @(negedge clk);
        @(negedge clk);
        chk("mrg_in_merge", 32'(dut.state_q), 32'(ST_MERGE));
        reset = 1'b1;
        drop_reqs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrg_rst_en", {31'b0, ram_en}, 32'd0);
        chk("mrg_rst_we", {31'b0, ram_we}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mrg_wcnt",  32'(wcount - w0), 32'd0);
        chk("mrg_mem",   mem[8], 32'h11223344);
        chk("mrg_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("mrg_d_rdata",  d_rdata,  32'd0);
        chk("mrg_if_rdata", if_rdata, 32'd0);
        last_if = '0;
        last_d  = '0;

        for (int i = 0; i < NV; i++) run_vec(i);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
